// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, widths and level wrap helper for the player status block
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    INVULN     = 3'd2,
    LEVEL_DONE = 3'd3,
    GAME_OVER  = 3'd4
  } game_state_t;

  function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] cur,
                                                    input logic [LEVEL_W-1:0] last);
    return (cur == last) ? '0 : cur + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - loadable frame down-counter with expiry strobe
// PLAYER_BLINK_EN adds a blink tap taken from the next count value.
module frame_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
`ifdef PLAYER_BLINK_EN
  ,
  output logic             blink_hide
`endif
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (load)
      count_nxt = load_val;
    else if (en && (count != '0))
      count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else
      count <= count_nxt;
  end

  // Fires on the frame that takes the count from 1 to 0.
  assign expire = en && (count == CNT_W'(1));

`ifdef PLAYER_BLINK_EN
  assign blink_hide = count_nxt[2];
`endif

endmodule

// File: rtl/player_status_fsm.sv
// rtl/player_status_fsm.sv - player lives/level/state controller with registered outputs
// PLAYER_BLINK_EN makes the player sprite blink while invulnerable.
module player_status_fsm
  import game_pkg::*;
#(
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int LEVEL_FRAMES  = 90,
  parameter int NUM_LEVELS    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               SingleHitPulse_player,
  input  logic               player_door_idol,
  output logic [2:0]         game_state,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               freeze_motion,
  output logic               player_visible,
  output logic               level_done_pulse
);

  game_state_t        state;
  game_state_t        state_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [LEVEL_W-1:0] level_nxt;
  logic               cnt_en;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_expire;
  logic               freeze_nxt;
  logic               visible_nxt;
  logic               done_pulse_nxt;
`ifdef PLAYER_BLINK_EN
  logic               blink_hide;
`endif

  assign cnt_en = startOfFrame && ((state == INVULN) || (state == LEVEL_DONE));

  frame_counter u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (cnt_en),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .expire     (cnt_expire)
`ifdef PLAYER_BLINK_EN
    ,
    .blink_hide (blink_hide)
`endif
  );

  always_comb begin
    state_nxt    = state;
    lives_nxt    = lives;
    level_nxt    = level;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_game) begin
          state_nxt = PLAY;
          lives_nxt = LIVES_W'(INIT_LIVES);
          level_nxt = '0;
        end
      end
      PLAY: begin
        // The door wins over a simultaneous hit, so no life is lost.
        if (player_door_idol) begin
          state_nxt    = LEVEL_DONE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(LEVEL_FRAMES);
        end else if (SingleHitPulse_player) begin
          if (lives > LIVES_W'(1)) begin
            state_nxt    = INVULN;
            lives_nxt    = lives - LIVES_W'(1);
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(INVULN_FRAMES);
          end else begin
            state_nxt = GAME_OVER;
            lives_nxt = '0;
          end
        end
      end
      INVULN: begin
        if (player_door_idol) begin
          state_nxt    = LEVEL_DONE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(LEVEL_FRAMES);
        end else if (cnt_expire) begin
          state_nxt = PLAY;
        end
      end
      LEVEL_DONE: begin
        if (cnt_expire) begin
          state_nxt = PLAY;
          level_nxt = next_level(level, LEVEL_W'(NUM_LEVELS - 1));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    freeze_nxt     = (state_nxt == IDLE) || (state_nxt == LEVEL_DONE) || (state_nxt == GAME_OVER);
    visible_nxt    = !((state_nxt == IDLE) || (state_nxt == GAME_OVER));
    done_pulse_nxt = (state_nxt == LEVEL_DONE) && (state != LEVEL_DONE);
`ifdef PLAYER_BLINK_EN
    if ((state_nxt == INVULN) && blink_hide)
      visible_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      lives            <= '0;
      level            <= '0;
      freeze_motion    <= 1'b1;
      player_visible   <= 1'b0;
      level_done_pulse <= 1'b0;
    end else begin
      state            <= state_nxt;
      lives            <= lives_nxt;
      level            <= level_nxt;
      freeze_motion    <= freeze_nxt;
      player_visible   <= visible_nxt;
      level_done_pulse <= done_pulse_nxt;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_player_status_fsm.sv
// tb/tb_player_status_fsm.sv - directed self-checking bench for player_status_fsm
module tb_player_status_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       start_game = 1'b0;
  logic       SingleHitPulse_player = 1'b0;
  logic       player_door_idol = 1'b0;
  logic [2:0] game_state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       freeze_motion;
  logic       player_visible;
  logic       level_done_pulse;

  int total = 0;
  int bad = 0;
  int exp_level;

  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_INV = 3'd2, S_LD = 3'd3, S_GO = 3'd4;

  always #5 clk = ~clk;

  player_status_fsm dut (
    .clk                   (clk),
    .reset                 (reset),
    .startOfFrame          (startOfFrame),
    .start_game            (start_game),
    .SingleHitPulse_player (SingleHitPulse_player),
    .player_door_idol      (player_door_idol),
    .game_state            (game_state),
    .lives                 (lives),
    .level                 (level),
    .freeze_motion         (freeze_motion),
    .player_visible        (player_visible),
    .level_done_pulse      (level_done_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
  endtask

  task automatic hit();
    SingleHitPulse_player = 1'b1; tick(); SingleHitPulse_player = 1'b0;
  endtask

  task automatic start();
    start_game = 1'b1; tick(); start_game = 1'b0;
  endtask

  task automatic door();
    player_door_idol = 1'b1; tick(); player_door_idol = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    total++; if (game_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", game_state, S_IDLE); end
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL reset_lives got=%0d exp=0", lives); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (freeze_motion !== 1'b1) begin bad++; $display("FAIL reset_freeze got=%0b exp=1", freeze_motion); end
    total++; if (player_visible !== 1'b0) begin bad++; $display("FAIL reset_visible got=%0b exp=0", player_visible); end
    total++; if (level_done_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b exp=0", level_done_pulse); end
    reset = 1'b0; tick();
    total++; if (game_state !== S_IDLE) begin bad++; $display("FAIL idle_hold got=%0d exp=%0d", game_state, S_IDLE); end
  endtask

  task automatic test_start();
    start();
    total++; if (game_state !== S_PLAY) begin bad++; $display("FAIL start_state got=%0d exp=%0d", game_state, S_PLAY); end
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL start_lives got=%0d exp=3", lives); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL start_level got=%0d exp=0", level); end
    total++; if (freeze_motion !== 1'b0) begin bad++; $display("FAIL start_freeze got=%0b exp=0", freeze_motion); end
    total++; if (player_visible !== 1'b1) begin bad++; $display("FAIL start_visible got=%0b exp=1", player_visible); end
    start();
    total++; if (game_state !== S_PLAY) begin bad++; $display("FAIL start_ignored_play got=%0d exp=%0d", game_state, S_PLAY); end
  endtask

  task automatic test_invuln();
    hit();
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit_lives got=%0d exp=2", lives); end
    total++; if (game_state !== S_INV) begin bad++; $display("FAIL hit_state got=%0d exp=%0d", game_state, S_INV); end
    total++; if (player_visible !== 1'b1) begin bad++; $display("FAIL inv_visible got=%0b exp=1", player_visible); end
    total++; if (freeze_motion !== 1'b0) begin bad++; $display("FAIL inv_freeze got=%0b exp=0", freeze_motion); end
    start();
    total++; if (game_state !== S_INV) begin bad++; $display("FAIL start_ignored_inv got=%0d exp=%0d", game_state, S_INV); end
    repeat (5) begin hit(); tick(); end
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL inv_hits_lives got=%0d exp=2", lives); end
    frames(59);
    total++; if (game_state !== S_INV) begin bad++; $display("FAIL inv_59_state got=%0d exp=%0d", game_state, S_INV); end
    frames(1);
    total++; if (game_state !== S_PLAY) begin bad++; $display("FAIL inv_60_state got=%0d exp=%0d", game_state, S_PLAY); end
  endtask

  task automatic test_game_over();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    start();
    hit(); frames(60);
    hit(); frames(60);
    hit();
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL go_lives got=%0d exp=0", lives); end
    total++; if (game_state !== S_GO) begin bad++; $display("FAIL go_state got=%0d exp=%0d", game_state, S_GO); end
    total++; if (player_visible !== 1'b0) begin bad++; $display("FAIL go_visible got=%0b exp=0", player_visible); end
    total++; if (freeze_motion !== 1'b1) begin bad++; $display("FAIL go_freeze got=%0b exp=1", freeze_motion); end
    hit(); tick();
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL go_saturate got=%0d exp=0", lives); end
    start();
    total++; if (game_state !== S_PLAY) begin bad++; $display("FAIL restart_state got=%0d exp=%0d", game_state, S_PLAY); end
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL restart_lives got=%0d exp=3", lives); end
  endtask

  task automatic test_door_hit();
    player_door_idol = 1'b1; SingleHitPulse_player = 1'b1; tick();
    player_door_idol = 1'b0; SingleHitPulse_player = 1'b0;
    total++; if (game_state !== S_LD) begin bad++; $display("FAIL door_hit_state got=%0d exp=%0d", game_state, S_LD); end
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL door_hit_lives got=%0d exp=3", lives); end
    total++; if (level_done_pulse !== 1'b1) begin bad++; $display("FAIL door_pulse_on got=%0b exp=1", level_done_pulse); end
    total++; if (freeze_motion !== 1'b1) begin bad++; $display("FAIL ld_freeze got=%0b exp=1", freeze_motion); end
    tick();
    total++; if (level_done_pulse !== 1'b0) begin bad++; $display("FAIL door_pulse_off got=%0b exp=0", level_done_pulse); end
    frames(89);
    total++; if (game_state !== S_LD) begin bad++; $display("FAIL ld_89_state got=%0d exp=%0d", game_state, S_LD); end
    frames(1);
    total++; if (game_state !== S_PLAY) begin bad++; $display("FAIL ld_90_state got=%0d exp=%0d", game_state, S_PLAY); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL ld_level got=%0d exp=1", level); end
  endtask

  task automatic test_door_in_invuln();
    hit(); frames(10);
    door();
    total++; if (game_state !== S_LD) begin bad++; $display("FAIL inv_door_state got=%0d exp=%0d", game_state, S_LD); end
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL inv_door_lives got=%0d exp=2", lives); end
    total++; if (level_done_pulse !== 1'b1) begin bad++; $display("FAIL inv_door_pulse got=%0b exp=1", level_done_pulse); end
    frames(90);
    total++; if (level !== 4'd2) begin bad++; $display("FAIL inv_door_level got=%0d exp=2", level); end
  endtask

  task automatic test_level_wrap();
    exp_level = 2;
    for (int i = 0; i < 4; i++) begin
      exp_level = (exp_level + 1) % 4;
      door();
      frames(89);
      total++; if (game_state !== S_LD) begin bad++; $display("FAIL wrap_hold_%0d got=%0d exp=%0d", i, game_state, S_LD); end
      frames(1);
      total++; if (level !== 4'(exp_level)) begin bad++; $display("FAIL wrap_level_%0d got=%0d exp=%0d", i, level, exp_level); end
    end
  endtask

  task automatic test_reset_mid_count();
    bit seen_pulse;
    hit(); frames(30);
    reset = 1'b1; #1;
    total++; if (game_state !== S_IDLE) begin bad++; $display("FAIL mid_reset_state got=%0d exp=%0d", game_state, S_IDLE); end
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL mid_reset_lives got=%0d exp=0", lives); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL mid_reset_level got=%0d exp=0", level); end
    total++; if (freeze_motion !== 1'b1) begin bad++; $display("FAIL mid_reset_freeze got=%0b exp=1", freeze_motion); end
    total++; if (player_visible !== 1'b0) begin bad++; $display("FAIL mid_reset_visible got=%0b exp=0", player_visible); end
    tick(); reset = 1'b0;
    frames(40);
    total++; if (game_state !== S_IDLE) begin bad++; $display("FAIL post_reset_state got=%0d exp=%0d", game_state, S_IDLE); end
    start(); door(); frames(10);
    reset = 1'b1; #1;
    total++; if (level_done_pulse !== 1'b0) begin bad++; $display("FAIL ld_reset_pulse got=%0b exp=0", level_done_pulse); end
    tick(); reset = 1'b0;
    seen_pulse = 1'b0;
    repeat (100) begin
      startOfFrame = 1'b1; tick(); seen_pulse |= level_done_pulse;
      startOfFrame = 1'b0; tick(); seen_pulse |= level_done_pulse;
    end
    total++; if (seen_pulse !== 1'b0) begin bad++; $display("FAIL ld_residual_pulse got=%0b exp=0", seen_pulse); end
    total++; if (game_state !== S_IDLE) begin bad++; $display("FAIL ld_reset_state got=%0d exp=%0d", game_state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_invuln();
    test_game_over();
    test_door_hit();
    test_door_in_invuln();
    test_level_wrap();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_status_fsm.md
PLAYER_STATUS_FSM -- requirements
Module: player_status_fsm

Interface
REQ-001 SHALL have parameter INIT_LIVES, default 3, meaning lives loaded at game start (1..7).
REQ-002 SHALL have parameter INVULN_FRAMES, default 60, meaning frames of immunity after a hit (1..255).
REQ-003 SHALL have parameter LEVEL_FRAMES, default 90, meaning frames spent in LEVEL_DONE before the next level (1..255).
REQ-004 SHALL have parameter NUM_LEVELS, default 4, meaning level count before the level index wraps (2..16).
REQ-005 SHALL have port clk, input, 1, meaning the system clock; the block uses this one clock.
REQ-006 SHALL have port reset, input, 1, meaning reset; it is asynchronous and active-high.
REQ-007 SHALL have port startOfFrame, input, 1, meaning a one-cycle pulse once per frame.
REQ-008 SHALL have port start_game, input, 1, meaning a one-cycle start request from the keypad.
REQ-009 SHALL have port SingleHitPulse_player, input, 1, meaning at most one pulse per frame from the collision controller.
REQ-010 SHALL have port player_door_idol, input, 1, meaning a level signal for player/door pixel overlap.
REQ-011 SHALL have port game_state, output, 3, meaning the current state encoding.
REQ-012 SHALL have port lives, output, 3, meaning the remaining lives.
REQ-013 SHALL have port level, output, 4, meaning the current level index (0-based).
REQ-014 SHALL have port freeze_motion, output, 1, meaning movers hold position while high.
REQ-015 SHALL have port player_visible, output, 1, meaning the drawing enable for the player sprite.
REQ-016 SHALL have port level_done_pulse, output, 1, meaning one cycle, asserted on entry to LEVEL_DONE.

Function
REQ-017 SHALL implement states IDLE, PLAY, INVULN, LEVEL_DONE and GAME_OVER.
REQ-018 SHALL register every output; an output responds exactly 1 clk after the input event that causes it.
REQ-019 SHALL go IDLE->PLAY on start_game, loading lives=INIT_LIVES and level=0.
REQ-020 SHALL, in PLAY on SingleHitPulse_player with lives>1, decrement lives, load frame_cnt=INVULN_FRAMES and enter INVULN.
REQ-021 SHALL, in PLAY on SingleHitPulse_player with lives==1, set lives=0 and enter GAME_OVER.
REQ-022 SHALL, in INVULN, ignore hits and decrement frame_cnt on each startOfFrame; at frame_cnt==1 with startOfFrame it SHALL go to PLAY.
REQ-023 SHALL, in PLAY or INVULN when player_door_idol=1, enter LEVEL_DONE, pulse level_done_pulse and load frame_cnt=LEVEL_FRAMES.
REQ-024 SHALL give door priority over a hit in the same cycle; lives are then unchanged.
REQ-025 SHALL, in LEVEL_DONE, count frames as in INVULN; on expiry it SHALL go to PLAY with level=level+1, wrapping from NUM_LEVELS-1 to 0.
REQ-026 SHALL stay in GAME_OVER until start_game, then restart exactly as from IDLE.
REQ-027 SHALL ignore start_game in PLAY, INVULN and LEVEL_DONE.
REQ-028 SHALL hold freeze_motion=1 in IDLE, LEVEL_DONE and GAME_OVER, and 0 otherwise.
REQ-029 SHALL hold player_visible=0 in IDLE and GAME_OVER, and 1 otherwise unless the blink option modifies it.
REQ-030 SHALL saturate lives at 0 and never underflow.

Reset
REQ-031 SHALL, while reset=1, immediately force state=IDLE, lives=0, level=0, frame_cnt=0, freeze_motion=1, player_visible=0 and level_done_pulse=0.
REQ-032 SHALL abandon any count in progress when reset is asserted mid-INVULN or mid-LEVEL_DONE, with no residual pulse after release.

Configuration
REQ-033 SHALL, with PLAYER_BLINK_EN defined, toggle player_visible every 4 frames in INVULN (frame_cnt[2]=1 -> hidden).
REQ-034 SHALL, without PLAYER_BLINK_EN, hold player_visible=1 throughout INVULN, and the blink logic SHALL be absent.

Structure
REQ-035 SHALL place the state enum (typedef game_state_t) and the width constants LIVES_W=3 and LEVEL_W=4 in the shared package game_pkg.
REQ-036 SHALL use sub-module frame_counter: a loadable down-counter clocked by startOfFrame-enable, with an expire output; it is used for both INVULN and LEVEL_DONE.

Verification
REQ-037 SHALL test: reset, then start_game -> next clk state=PLAY, lives=3, level=0, freeze_motion=0.
REQ-038 SHALL test: a hit in PLAY -> lives=2, state=INVULN; 5 more hits during INVULN -> lives stays 2; after 60 startOfFrame pulses -> PLAY.
REQ-039 SHALL test: three hits separated by full invulnerability -> lives=0, state=GAME_OVER, player_visible=0, freeze_motion=1.
REQ-040 SHALL test: hit and door in the same cycle -> LEVEL_DONE, lives unchanged, level_done_pulse high for exactly 1 cycle.
REQ-041 SHALL test: 4 consecutive level completions from level=3 -> level wraps to 0 after 90 frames.
REQ-042 SHALL test: reset asserted at frame_cnt=30 in INVULN -> IDLE with all outputs at reset values in the same cycle.
